main_mem_responder: RTL and testbench

//  Synthesizable main-memory slave for the cache controller's main-memory interface.

---
 rtl/main_mem_responder_if.sv | 21 ++
 rtl/main_mem_responder.sv | 124 ++++++++++++
 tb/tb_main_mem_responder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/main_mem_responder_if.sv
// Main-memory bus between the cache controller (master) and the memory (slave).
// The controller drives the address, write data and request levels. The memory
// returns a full 512-bit line and a one-cycle ready pulse.
interface main_mem_if;
  logic [31:0]  addr;
  logic [31:0]  data_out;
  logic         read_req;
  logic         write_req;
  logic [511:0] data_in;
  logic         ready;

  modport master (
    output addr, data_out, read_req, write_req,
    input  data_in, ready
  );

  modport slave (
    input  addr, data_out, read_req, write_req,
    output data_in, ready
  );
endinterface

// File: rtl/main_mem_responder.sv
// Synthesizable main-memory slave for the cache controller.
// It services line-fill reads and write-through word writes after a fixed
// latency, then returns a one-cycle ready pulse.
//
// state | meaning
// IDLE  | waiting for a request; address, data and op are latched on acceptance
// BUSY  | counting down the latency; the op commits on the edge where cnt == 0
// RESP  | ready is high for exactly this cycle
// HOLD  | waits for both requests to drop, so a held request is not serviced twice
//
// When INIT_PATTERN is set, the array stores each word XORed with its line base
// address. A zero-initialised simulation array then reads back as
// {line, 6'b0} per word without any fill logic. The stored value has no
// defined meaning in hardware.
module main_mem_responder #(
  parameter int LATENCY      = 3,
  parameter int LINE_IDX_W   = 8,
  parameter bit INIT_PATTERN = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  main_mem_if.slave bus,
  output logic     mem_busy_o,
  output logic     req_collision_o
);

  localparam int        LINES    = 1 << LINE_IDX_W;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, HOLD} state_t;

  state_t                state_q;
  logic [7:0]            cnt_q;
  logic                  op_write_q;
  logic [LINE_IDX_W-1:0] idx_q;
  logic [3:0]            word_q;
  logic [31:0]           wdata_q;
  logic [511:0]          data_in_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  coll_q;

  logic [511:0]          line_mem [LINES];

  logic [31:0]           pattern_d;
  logic [511:0]          line_rd_d;
  logic                  commit_write_d;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{bus.addr[31:LINE_IDX_W+6], bus.addr[1:0]};

  assign pattern_d      = INIT_PATTERN ? 32'({idx_q, 6'b0}) : 32'h0;
  assign line_rd_d      = line_mem[idx_q] ^ {16{pattern_d}};
  // The write is gated by rst so that an in-flight write is dropped when reset arrives on its commit edge.
  assign commit_write_d = (state_q == BUSY) && (cnt_q == 8'd0) && op_write_q && !rst;

  // Memory array: it has no reset, so its contents survive a controller reset.
  always_ff @(posedge clk) begin
    if (commit_write_d) begin
      line_mem[idx_q][{word_q, 5'b0} +: 32] <= wdata_q ^ pattern_d;
    end
  end

  // Request sequencing FSM, with registered ready, busy, collision and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      op_write_q <= 1'b0;
      idx_q      <= '0;
      word_q     <= 4'd0;
      wdata_q    <= 32'h0;
      data_in_q  <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.read_req || bus.write_req) begin
            idx_q      <= bus.addr[LINE_IDX_W+5:6];
            word_q     <= bus.addr[5:2];
            wdata_q    <= bus.data_out;
            op_write_q <= bus.write_req;
            cnt_q      <= CNT_INIT;
            busy_q     <= 1'b1;
            state_q    <= BUSY;
            if (bus.read_req && bus.write_req) begin
              coll_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (cnt_q == 8'd0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            if (!op_write_q) begin
              data_in_q <= line_rd_d;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          state_q <= HOLD;
        end
        HOLD: begin
          if (!bus.read_req && !bus.write_req) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_in     = data_in_q;
  assign bus.ready       = ready_q;
  assign mem_busy_o      = busy_q;
  assign req_collision_o = coll_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder. The main instance uses LATENCY=3.
// Two more instances with LATENCY=1 and LATENCY=8 check ready timing.
module tb_main_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  main_mem_if mif();
  main_mem_if if1();
  main_mem_if if8();

  logic busy3, coll3, busy1, coll1, busy8, coll8;

  main_mem_responder #(.LATENCY(3), .LINE_IDX_W(8), .INIT_PATTERN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .bus(mif.slave), .mem_busy_o(busy3), .req_collision_o(coll3));
  main_mem_responder #(.LATENCY(1), .LINE_IDX_W(8), .INIT_PATTERN(1'b1)) u_dut_l1 (
    .clk(clk), .rst(rst), .bus(if1.slave), .mem_busy_o(busy1), .req_collision_o(coll1));
  main_mem_responder #(.LATENCY(8), .LINE_IDX_W(8), .INIT_PATTERN(1'b1)) u_dut_l8 (
    .clk(clk), .rst(rst), .bus(if8.slave), .mem_busy_o(busy8), .req_collision_o(coll8));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues one request on the LATENCY=3 instance. It scrambles the address and data after acceptance,
  // then checks the ready edge, that no second pulse appears, that busy stays high while the request is held, and the HOLD exit.
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input string tag);
    int lat;
    int extra_pulses;
    int busy_low;
    @(negedge clk);
    mif.addr = a; mif.data_out = d; mif.read_req = rd; mif.write_req = wr;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        mif.addr = ~a; mif.data_out = ~d;
      end
      if (mif.ready) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, " ready_edge"}, 512'(lat), 512'(4));
    extra_pulses = 0;
    busy_low = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (mif.ready) extra_pulses++;
      if (!busy3) busy_low++;
    end
    check_eq({tag, " extra_pulses"}, 512'(extra_pulses), 512'(0));
    check_eq({tag, " busy_held"}, 512'(busy_low), 512'(0));
    @(negedge clk);
    mif.read_req = 1'b0; mif.write_req = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, " busy_exit"}, 512'(busy3), 512'(0));
  endtask

  logic [511:0] exp_line;
  int ready_cnt;
  int first1, first3, first8;

  initial begin
    mif.addr = '0; mif.data_out = '0; mif.read_req = 1'b0; mif.write_req = 1'b0;
    if1.addr = '0; if1.data_out = '0; if1.read_req = 1'b0; if1.write_req = 1'b0;
    if8.addr = '0; if8.data_out = '0; if8.read_req = 1'b0; if8.write_req = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst ready", 512'(mif.ready), 512'(0));
    check_eq("rst data_in", mif.data_in, 512'(0));
    check_eq("rst busy", 512'(busy3), 512'(0));
    check_eq("rst collision", 512'(coll3), 512'(0));
    rst = 1'b0;

    // T1: reset asserted one cycle into BUSY
    @(negedge clk);
    mif.addr = 32'h1000; mif.read_req = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("t1 busy_before_rst", 512'(busy3), 512'(1));
    rst = 1'b1; mif.read_req = 1'b0;
    #1;
    check_eq("t1 busy_async", 512'(busy3), 512'(0));
    @(negedge clk);
    rst = 1'b0;
    ready_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (mif.ready) ready_cnt++;
    end
    check_eq("t1 no_ready", 512'(ready_cnt), 512'(0));
    check_eq("t1 data_in", mif.data_in, 512'(0));
    check_eq("t1 busy", 512'(busy3), 512'(0));

    // T2 and T5: fill read with the request held after ready
    do_op(1'b1, 1'b0, 32'h1000, 32'h0, "t2 read");
    check_eq("t2 data", mif.data_in, {16{32'h0000_1000}});

    // T3: write-through, then read back
    do_op(1'b0, 1'b1, 32'h2000, 32'hDEAD_BEEF, "t3 write");
    check_eq("t3 data_unchanged", mif.data_in, {16{32'h0000_1000}});
    do_op(1'b1, 1'b0, 32'h2000, 32'h0, "t3 read");
    check_eq("t3 data", mif.data_in, {{15{32'h0000_2000}}, 32'hDEAD_BEEF});

    // T4: word 15 of the same line, read through an aliased address
    do_op(1'b0, 1'b1, 32'h203C, 32'hCAFE_F00D, "t4 write");
    do_op(1'b1, 1'b0, 32'h2000 + (32'h1 << 14), 32'h0, "t4 read");
    exp_line = {32'hCAFE_F00D, {14{32'h0000_2000}}, 32'hDEAD_BEEF};
    check_eq("t4 data", mif.data_in, exp_line);

    // T6: read and write requested together
    do_op(1'b1, 1'b1, 32'h3000, 32'h1234_5678, "t6 coll");
    check_eq("t6 collision", 512'(coll3), 512'(1));
    check_eq("t6 data_unchanged", mif.data_in, exp_line);
    do_op(1'b1, 1'b0, 32'h3000, 32'h0, "t6 read");
    check_eq("t6 collision_sticky", 512'(coll3), 512'(1));
    check_eq("t6 data", mif.data_in, {{15{32'h0000_3000}}, 32'h1234_5678});

    // Reset clears the collision flag and read data, but not the array
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_eq("rst2 collision", 512'(coll3), 512'(0));
    check_eq("rst2 data_in", mif.data_in, 512'(0));
    do_op(1'b1, 1'b0, 32'h2000, 32'h0, "persist read");
    check_eq("persist data", mif.data_in, exp_line);

    // Latency sweep 1/3/8 on the fill read
    @(negedge clk);
    if1.addr = 32'h1000; if1.read_req = 1'b1;
    mif.addr = 32'h1000; mif.read_req = 1'b1;
    if8.addr = 32'h1000; if8.read_req = 1'b1;
    first1 = 0; first3 = 0; first8 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (if1.ready && first1 == 0) first1 = k;
      if (mif.ready && first3 == 0) first3 = k;
      if (if8.ready && first8 == 0) first8 = k;
    end
    check_eq("sweep L1 edge", 512'(first1), 512'(2));
    check_eq("sweep L3 edge", 512'(first3), 512'(4));
    check_eq("sweep L8 edge", 512'(first8), 512'(9));
    check_eq("sweep L1 data", if1.data_in, {16{32'h0000_1000}});
    check_eq("sweep L8 data", if8.data_in, {16{32'h0000_1000}});
    @(negedge clk);
    if1.read_req = 1'b0; mif.read_req = 1'b0; if8.read_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("sweep idle", 512'({busy1, busy3, busy8}), 512'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
